// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over WIDTH cycles, with sign fix-up in a final cycle into HI/LO.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic               neg_res;

  // Handshake: start is taken only in IDLE (start beats abort there); busy
  // stays high from the accept edge until the FIX edge or an abort edge;
  // done is a single-cycle pulse coincident with the HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    mag_a     = (op[0] && a[WIDTH-1]) ? -a : a;
    mag_b     = (op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    neg_res   = op_q[0] & (sa_q ^ sb_q);
    prod_fix  = neg_res ? -acc_q : acc_q;
    quo_fix   = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Remainder follows the dividend; with a zero divisor it is |a|, so this
    // also rebuilds the original a for the divide-by-zero result.
    rem_fix   = (op_q[0] & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op;
          sa_d    = op[0] & a[WIDTH-1];
          sb_d    = op[0] & b[WIDTH-1];
          bz_d    = (b == '0);
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          if (op_q[1]) begin
            if (!div_trial[WIDTH+1])
              acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!abort) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            hi_d  = rem_fix;
            lo_d  = bz_q ? '1 : quo_fix;
            dbz_d = bz_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
            dbz_d        = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the 32-bit MIPS datapath; the parametrised successor of the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds results in HI/LO registers.
- Sits beside the ALU. The control unit issues an operation with a start pulse and stalls on busy.

Parameters:
- WIDTH, 32: operand width in bits; HI and LO are each WIDTH bits.
- CW, 6: iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle.
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
- abort  input  1  synchronous cancel of the operation in flight.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI and LO are updated.
- div_by_zero  output  1  valid with done; set for a divide with b==0.
- hi  output  WIDTH  MULT: product high half; DIV: remainder.
- lo  output  WIDTH  MULT: product low half; DIV: quotient.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - The counter and internal operand registers are cleared.
- States: IDLE, CALC, FIX.
- IDLE with start=1 at edge E0:
  - Latch op, plus |a| and |b| (magnitudes for signed ops) and the sign flags.
  - Clear the counter; go to CALC. busy=1 from E0.
- start while busy is ignored; the latched operands are not disturbed.
- CALC: one iteration per edge, at E1..E_WIDTH; the counter increments each edge.
  - When the counter reaches WIDTH-1, go to FIX.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
- FIX at edge E_(WIDTH+1):
  - Apply sign correction.
  - Write hi and lo, assert done=1 for exactly one cycle, set busy=0, return to IDLE.
  - Total latency: done is high in the cycle after WIDTH+1 edges from accept (33 for WIDTH=32).
- done deasserts on the next edge unconditionally.
- start may be asserted in the done cycle and is accepted, giving back-to-back operation.
- Signed multiply: the full 2*WIDTH two's-complement product is written as hi:lo.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN / -1: lo=MIN, hi=0, with no flag.
- Divide by zero (b==0 for DIVU or DIV):
  - Same latency as a normal divide.
  - lo = all ones, hi = a (the original, unsigned view), div_by_zero=1 with done.
  - div_by_zero clears on the next accepted start.
- Multiply ops always produce div_by_zero=0.
- abort=1 while busy:
  - Return to IDLE on that edge; busy=0.
  - No done pulse; hi, lo and div_by_zero keep their previous values.
  - abort has no effect in IDLE.
  - abort and start in the same cycle while idle: start wins.
- hi and lo change only at the FIX edge or on reset.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 33 after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; immediately after, start is accepted in the done cycle with MULTU 6x7 -> hi=0, lo=42.
- DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIV a=0x12345678 b=0 -> done at cycle 33, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678; the next MULTU clears div_by_zero.
- Start MULTU 3x5 to completion, then start DIVU 100/7 and assert abort at cycle 10 -> busy falls, no done, hi=0, lo=15 retained. A start pulse issued at cycle 5 of a run is ignored, and the result matches the original operands.
- rst_n pulsed low at cycle 20 of a MULT -> hi, lo, busy and done read 0 immediately (before the next edge); a new op after release completes normally.
